// File: rtl/spi_stream_rx.sv
// -----------------------------------------------------------------------------
// spi_stream_rx
//
// SPI slave receiver (mode 0 sampling on the rising SPI clock edge) that packs
// serial bits into WORD_W-bit words and delivers them on an AXI4-Stream master
// port through a show-ahead FIFO. The last complete word of every chip-select
// frame is tagged with axis_tlast. A trailing partial word is discarded and
// reported with a one-cycle frag_drop pulse. Words that find the FIFO full are
// dropped and reported on the sticky ovf_flag.
//
// Parameters
//   WORD_W      bits per SPI word and axis_tdata width (4..32)
//   FIFO_DEPTH  output FIFO entries (power of 2, >= 2)
//   MSB_FIRST   0: first received bit lands in bit 0, 1: in bit WORD_W-1
//
// Ports
//   axi_aclk     system clock
//   axi_aresetn  asynchronous active-low reset
//   spi_clk      SPI clock (asynchronous to axi_aclk)
//   spi_mosi     SPI data (asynchronous)
//   spi_cs       chip select, active high (asynchronous)
//   axis_tdata   head-of-FIFO word
//   axis_tvalid  FIFO not empty
//   axis_tready  downstream accept
//   axis_tlast   head word is the last complete word of its frame
//   ovf_clr      clears ovf_flag
//   ovf_flag     sticky, a word was dropped on a full FIFO
//   frag_drop    one-cycle pulse, partial word discarded at frame end
//   fifo_level   current FIFO occupancy
// -----------------------------------------------------------------------------
module spi_stream_rx #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          spi_clk,
    input  logic                          spi_mosi,
    input  logic                          spi_cs,
    output logic [WORD_W-1:0]             axis_tdata,
    output logic                          axis_tvalid,
    input  logic                          axis_tready,
    output logic                          axis_tlast,
    input  logic                          ovf_clr,
    output logic                          ovf_flag,
    output logic                          frag_drop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_W);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE,
        FLUSH
    } state_t;

    state_t              state;

    logic                spi_clk_p0, spi_clk_p1, spi_clk_p2;
    logic                spi_mosi_p0, spi_mosi_p1;
    logic                spi_cs_p0, spi_cs_p1;
    logic [1:0]          sync_cnt;
    logic                sync_rdy;
    logic                strobe;

    logic [CW-1:0]       bit_cnt;
    logic [CW-1:0]       bit_idx;
    logic [WORD_W-1:0]   shift_p0;
    logic [WORD_W-1:0]   word_nxt;
    logic                sample;
    logic                word_done;

    logic [WORD_W-1:0]   stg_data;
    logic                stg_vld;

    logic                push_vld_p0;
    logic                push_last_p0;
    logic [WORD_W-1:0]   push_data_p0;

    logic [WORD_W:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [WORD_W:0]     head;
    logic                full;
    logic                pop;
    logic                push_ok;

    // ---- stage p0/p1: two-flop synchronisers, p2 holds previous synced clock
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            spi_clk_p0  <= 1'b0;
            spi_clk_p1  <= 1'b0;
            spi_clk_p2  <= 1'b0;
            spi_mosi_p0 <= 1'b0;
            spi_mosi_p1 <= 1'b0;
            spi_cs_p0   <= 1'b0;
            spi_cs_p1   <= 1'b0;
        end else begin
            spi_clk_p0  <= spi_clk;
            spi_clk_p1  <= spi_clk_p0;
            spi_clk_p2  <= spi_clk_p1;
            spi_mosi_p0 <= spi_mosi;
            spi_mosi_p1 <= spi_mosi_p0;
            spi_cs_p0   <= spi_cs;
            spi_cs_p1   <= spi_cs_p0;
        end
    end

    // Synchronisers restart from zero after reset, so a low synced CS is only
    // trusted once the chain has been refilled from the real pins; otherwise a
    // frame still in progress would look like an idle bus.
    assign sync_rdy  = (sync_cnt == 2'd2);
    assign strobe    = spi_clk_p1 & ~spi_clk_p2 & spi_cs_p1;
    assign sample    = (state == ACTIVE) && strobe;
    assign word_done = sample && (bit_cnt == CW'(WORD_W - 1));
    assign bit_idx   = MSB_FIRST ? (CW'(WORD_W - 1) - bit_cnt) : bit_cnt;

    always_comb begin
        word_nxt          = shift_p0;
        word_nxt[bit_idx] = spi_mosi_p1;
    end

    // ---- stage p0: frame FSM, bit counter, staging and push request
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state        <= WAIT_IDLE;
            sync_cnt     <= 2'd0;
            bit_cnt      <= '0;
            stg_vld      <= 1'b0;
            push_vld_p0  <= 1'b0;
            push_last_p0 <= 1'b0;
            frag_drop    <= 1'b0;
        end else begin
            push_vld_p0  <= 1'b0;
            push_last_p0 <= 1'b0;
            frag_drop    <= 1'b0;
            if (!sync_rdy) begin
                sync_cnt <= sync_cnt + 2'd1;
            end
            case (state)
                WAIT_IDLE: begin
                    if (sync_rdy && !spi_cs_p1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (spi_cs_p1) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!spi_cs_p1) begin
                        state <= FLUSH;
                    end else if (strobe) begin
                        if (bit_cnt == CW'(WORD_W - 1)) begin
                            bit_cnt <= '0;
                            stg_vld <= 1'b1;
                            // The word already staged is not the last of the
                            // frame, since a newer one has just completed.
                            push_vld_p0 <= stg_vld;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    if (stg_vld) begin
                        push_vld_p0  <= 1'b1;
                        push_last_p0 <= 1'b1;
                        stg_vld      <= 1'b0;
                    end
                    if (bit_cnt != '0) begin
                        frag_drop <= 1'b1;
                        bit_cnt   <= '0;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    // Data registers carry no reset; stg_vld and push_vld_p0 qualify them.
    always_ff @(posedge axi_aclk) begin
        if (sample) begin
            shift_p0 <= word_nxt;
        end
        if (word_done) begin
            stg_data <= word_nxt;
        end
        push_data_p0 <= stg_data;
    end

    // ---- stage p1: output FIFO
    assign full        = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign axis_tvalid = (fifo_level != '0);
    assign pop         = axis_tvalid & axis_tready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok     = push_vld_p0 & (~full | pop);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
            // A fresh overflow takes priority over a clear in the same cycle.
            if (push_vld_p0 && !push_ok) begin
                ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                ovf_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_last_p0, push_data_p0};
        end
    end

    // Head entry is gated by tvalid so the outputs read zero when empty.
    assign head       = mem[rd_ptr];
    assign axis_tdata = axis_tvalid ? head[WORD_W-1:0] : '0;
    assign axis_tlast = axis_tvalid & head[WORD_W];

endmodule
